pipe_chain: RTL and testbench

- Parametrised successor to the fixed single-register pipeline stage used between IF/ID/EX/MEM/WB.
- Provides a DEPTH-stage chain of WIDTH-bit payload registers, each with its own valid bit.
- Uses an elastic valid/ready handshake with a combinational ready chain, giving full throughput with bubble collapsing.
- Adds per-stage flush (kill), a global hold, occupancy reporting and a saturating flushed-entry counter, so the CPU pipeline can stall and flush without external glue.

---
 rtl/pipe_chain.sv | 104 ++++++++++
 tb/tb_pipe_chain.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// Elastic DEPTH-stage payload chain with per-stage valid bits, per-stage kill, global hold,
// registered occupancy and a saturating count of killed items.
module pipe_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNTW  = 8
) (
  input  logic                           clk,
  input  logic                           clr_n,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ready,
  input  logic                           hold,
  input  logic [DEPTH-1:0]               flush,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic [CNTW-1:0]                flushed_cnt
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);
  // Headroom for up to 16 kills added on top of a saturated count.
  localparam int unsigned SumW = CNTW + 5;

  logic [DEPTH-1:0] valid_q, valid_d, v_eff, rdy;
  logic [DEPTH:0]   src_v;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] src_d  [DEPTH];
  logic             space;
  logic [OccW-1:0]  occ_d;
  logic [SumW-1:0]  cnt_sum;
  logic [CNTW-1:0]  cnt_d;

  // A killed occupant never takes part in any handshake this cycle.
  assign v_eff = valid_q & ~flush;
  assign src_v = {v_eff, in_valid};

  // Stage k can take a new item if any slot at or ahead of it is free, or the output drains.
  always_comb begin
    rdy   = '0;
    space = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      space  = space | ~v_eff[k];
      rdy[k] = ~hold & space;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_eff[DEPTH-1] & ~hold;
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    src_d[0] = in_data;
    for (int k = 1; k < int'(DEPTH); k++) begin
      src_d[k] = data_q[k-1];
    end
  end

  always_comb begin
    valid_d = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      data_d[k] = data_q[k];
      if (rdy[k]) begin
        valid_d[k] = src_v[k];
        if (src_v[k]) begin
          data_d[k] = src_d[k];
        end
      end else begin
        valid_d[k] = v_eff[k];
      end
    end
  end

  always_comb begin
    occ_d   = '0;
    cnt_sum = SumW'(flushed_cnt);
    for (int k = 0; k < int'(DEPTH); k++) begin
      occ_d   = occ_d + OccW'(valid_d[k]);
      cnt_sum = cnt_sum + SumW'(valid_q[k] & flush[k]);
    end
    cnt_d = (cnt_sum > SumW'({CNTW{1'b1}})) ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      valid_q     <= '0;
      occupancy   <= '0;
      flushed_cnt <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      occupancy   <= occ_d;
      flushed_cnt <= cnt_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: directed scenarios plus random traffic, all checked against a slot-level
// model where an item advances whenever the output drains or any slot ahead of it is empty.
module tb_pipe_chain;

  localparam int D    = 3;
  localparam int W    = 32;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic          hold = 1'b0;
  logic [D-1:0]  flush = '0;
  logic [1:0]    occupancy;
  logic [CW-1:0] flushed_cnt;

  pipe_chain #(.WIDTH(W), .DEPTH(D), .CNTW(CW)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .hold        (hold),
    .flush       (flush),
    .occupancy   (occupancy),
    .flushed_cnt (flushed_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit          m_v [D];
  logic [W-1:0] m_d [D];
  int          m_cnt;
  logic [W-1:0] outq [$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k < D; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end
    m_cnt = 0;
  endtask

  // Called just after a rising edge; drives one cycle of inputs and checks both sides of the edge.
  task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy, input bit hld,
                      input logic [D-1:0] fl, output bit taken);
    bit           ev [D];
    bit           nv [D];
    logic [W-1:0] nd [D];
    int           killed, neff, nocc;
    bit           e_ir, e_ov, ahead;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    hold      = hld;
    flush     = fl;
    #1;
    killed = 0;
    neff   = 0;
    for (int k = 0; k < D; k++) begin
      ev[k]  = m_v[k] && !fl[k];
      killed += int'(m_v[k] && fl[k]);
      neff   += int'(ev[k]);
      nv[k]  = 1'b0;
      nd[k]  = m_d[k];
    end
    if (hld) begin
      e_ir = 1'b0;
      e_ov = 1'b0;
      for (int k = 0; k < D; k++) nv[k] = ev[k];
    end else begin
      e_ir = ordy || (neff < D);
      e_ov = ev[D-1];
      for (int k = D - 1; k >= 0; k--) begin
        if (ev[k]) begin
          ahead = ordy;
          for (int j = k + 1; j < D; j++) if (!ev[j]) ahead = 1'b1;
          if (!ahead) nv[k] = 1'b1;
          else if (k < D - 1) begin
            nv[k+1] = 1'b1;
            nd[k+1] = m_d[k];
          end
        end
      end
      if (iv && e_ir) begin
        nv[0] = 1'b1;
        nd[0] = id;
      end
    end
    check("in_ready", W'(in_ready), W'(e_ir));
    check("out_valid", W'(out_valid), W'(e_ov));
    check("out_data", out_data, m_d[D-1]);
    taken = iv && in_ready;
    if (out_valid && ordy) outq.push_back(out_data);
    @(posedge clk);
    #1;
    nocc = 0;
    for (int k = 0; k < D; k++) begin
      m_v[k] = nv[k];
      m_d[k] = nd[k];
      nocc  += int'(nv[k]);
    end
    m_cnt = (m_cnt + killed > CMAX) ? CMAX : m_cnt + killed;
    check("occupancy", W'(occupancy), W'(nocc));
    check("flushed_cnt", W'(flushed_cnt), W'(m_cnt));
  endtask

  // Asserts reset between edges and checks that state clears before any edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hold      = 1'b0;
    flush     = '0;
    clr_n     = 1'b0;
    #2;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_occupancy", W'(occupancy), '0);
    check("rst_flushed_cnt", W'(flushed_cnt), '0);
    check("rst_in_ready", W'(in_ready), 32'd1);
    model_clear();
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    bit t;
    step(1'b1, a, 1'b0, 1'b0, '0, t);
    step(1'b1, b, 1'b0, 1'b0, '0, t);
    step(1'b1, c, 1'b0, 1'b0, '0, t);
  endtask

  initial begin
    bit           t;
    int           nacc, peak;
    logic [W-1:0] items [5];
    @(posedge clk);
    #1;
    do_reset();

    // Streaming with a free-running sink.
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(1'b1, W'((i + 1) * 'h11), 1'b1, 1'b0, '0, t);
      else step(1'b0, '0, 1'b1, 1'b0, '0, t);
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    check("stream_peak", W'(peak), 32'd3);
    check("stream_n", W'(outq.size()), 32'd4);
    for (int i = 0; i < outq.size() && i < 4; i++) check("stream_order", outq[i], W'((i + 1) * 'h11));
    outq.delete();

    // Backpressure fill then drain with the remaining items queued behind.
    for (int i = 0; i < 5; i++) items[i] = $urandom;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, items[nacc], 1'b0, 1'b0, '0, t);
      if (t) nacc++;
    end
    check("bp_accepted", W'(nacc), 32'd3);
    check("bp_occ", W'(occupancy), 32'd3);
    check("bp_head", out_data, items[0]);
    for (int i = 0; i < 10; i++) begin
      if (nacc < 5) begin
        step(1'b1, items[nacc], 1'b1, 1'b0, '0, t);
        if (t) nacc++;
      end else step(1'b0, '0, 1'b1, 1'b0, '0, t);
    end
    check("bp_drained", W'(outq.size()), 32'd5);
    for (int i = 0; i < outq.size() && i < 5; i++) check("bp_order", outq[i], items[i]);
    outq.delete();

    // Bubble collapse: items in stages 2 and 0, stage 1 empty.
    do_reset();
    step(1'b1, 32'hA0, 1'b0, 1'b0, '0, t);
    step(1'b0, '0, 1'b0, 1'b0, '0, t);
    step(1'b1, 32'hB0, 1'b0, 1'b0, '0, t);
    step(1'b0, '0, 1'b0, 1'b0, '0, t);
    check("bub_occ", W'(occupancy), 32'd2);
    check("bub_head", out_data, 32'hA0);

    // Kill the middle stage of a full chain.
    do_reset();
    fill3(32'hC, 32'hB, 32'hA);
    step(1'b0, '0, 1'b0, 1'b0, 3'b010, t);
    check("fm_cnt", W'(flushed_cnt), 32'd1);
    check("fm_occ", W'(occupancy), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, '0, t);
    check("fm_n", W'(outq.size()), 32'd2);
    if (outq.size() == 2) begin
      check("fm_first", outq[0], 32'hC);
      check("fm_second", outq[1], 32'hA);
    end
    outq.delete();

    // Kill everything while a new item enters.
    do_reset();
    fill3(32'h1, 32'h2, 32'h3);
    step(1'b1, 32'h5A, 1'b0, 1'b0, 3'b111, t);
    check("fwe_occ", W'(occupancy), 32'd1);
    check("fwe_cnt", W'(flushed_cnt), 32'd3);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, '0, t);
    check("fwe_out", (outq.size() == 1) ? outq[0] : '1, 32'h5A);
    outq.delete();

    // Hold a full chain, then reset asynchronously mid-cycle.
    fill3(32'h7, 32'h8, 32'h9);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hEE, 1'b1, 1'b1, '0, t);
    check("hold_occ", W'(occupancy), 32'd3);
    check("hold_head", out_data, 32'h7);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [D-1:0] fl;
      for (int k = 0; k < D; k++) fl[k] = ($urandom_range(0, 7) == 0);
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 7) == 0), fl, t);
    end
    check("rand_cnt_sat", W'(flushed_cnt), W'(m_cnt));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
